// File: rtl/countdown_clock_pkg.sv
// Shared definitions for the MM:SS countdown clock: state encoding,
// BCD digit geometry and small conversion helpers.
package countdown_clock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam int DIGIT_W      = 4;
  localparam int DIGIT_MAX    = 9;
  localparam int SEC_TENS_MAX = 5;

  // Two-digit BCD encoding of a value in 0..99.
  function automatic logic [7:0] to_bcd2(input int unsigned value);
    return {4'(value / 10), 4'(value % 10)};
  endfunction

  // Total seconds represented by a packed {mt, mo, st, so} BCD value.
  function automatic logic [12:0] bcd_to_seconds(input logic [15:0] bcd);
    int unsigned mins;
    int unsigned secs;
    mins = int'(bcd[15:12]) * 10 + int'(bcd[11:8]);
    secs = int'(bcd[7:4]) * 10 + int'(bcd[3:0]);
    return 13'(mins * 60 + secs);
  endfunction

endpackage

// File: rtl/countdown_clock_bcd_digit_down.sv
// One BCD digit of the down-counting borrow chain. Produces the digit's
// next value: the clamped load value, a decrement with wrap to MAX, or a hold.
module bcd_digit_down
  import countdown_clock_pkg::*;
#(
  parameter int MAX = DIGIT_MAX
) (
  input  logic [DIGIT_W-1:0] digit,
  input  logic               borrow_in,
  input  logic               load_en,
  input  logic [DIGIT_W-1:0] load_digit,
  output logic [DIGIT_W-1:0] next_digit,
  output logic               borrow_out
);

  localparam logic [DIGIT_W-1:0] MAX_D = DIGIT_W'(MAX);

  // Load takes precedence; otherwise decrement only when borrowed into.
  always_comb begin
    next_digit = digit;
    borrow_out = 1'b0;
    if (load_en) begin
      next_digit = (load_digit > MAX_D) ? MAX_D : load_digit;
    end else if (borrow_in) begin
      if (digit == '0) begin
        next_digit = MAX_D;
        borrow_out = 1'b1;
      end else begin
        next_digit = digit - 1'b1;
      end
    end
  end

endmodule

// File: rtl/countdown_clock.sv
// MM:SS countdown clock. Decrements a BCD value once per incoming tick
// while running, with load/pause/start control, expiry and warning flags.
module countdown_clock
  import countdown_clock_pkg::*;
#(
  parameter int DEFAULT_MIN  = 1,
  parameter int DEFAULT_SEC  = 30,
  parameter int WARN_SECONDS = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        start,
  input  logic        pause,
  output logic [15:0] digits,
  output logic        running,
  output logic        expired,
  output logic        expired_pulse,
  output logic        warning
);

  localparam logic [15:0] RESET_DIGITS =
    {to_bcd2(DEFAULT_MIN), to_bcd2(DEFAULT_SEC)};

  state_t      state_reg, state_next;
  logic [15:0] digits_reg, digits_next;
  logic        expired_pulse_reg, expired_pulse_next;
  logic        dec_en;
  logic [4:0]  borrow;
  logic [12:0] remaining;
  logic        hits_zero;

  // A tick only counts in RUNNING and when neither load nor pause claims the cycle.
  assign dec_en    = (state_reg == RUNNING) && tick && !load && !pause;
  assign borrow[0] = dec_en;

  // Borrow chain, seconds-ones at index 0 up to minutes-tens at index 3.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      localparam int MAX = (gi == 1) ? SEC_TENS_MAX : DIGIT_MAX;
      bcd_digit_down #(.MAX(MAX)) u_digit (
        .digit      (digits_reg[gi*DIGIT_W +: DIGIT_W]),
        .borrow_in  (borrow[gi]),
        .load_en    (load),
        .load_digit (load_value[gi*DIGIT_W +: DIGIT_W]),
        .next_digit (digits_next[gi*DIGIT_W +: DIGIT_W]),
        .borrow_out (borrow[gi+1])
      );
    end
  endgenerate

  // A borrow out of the top digit would mean decrementing 00:00, which the
  // FSM never allows; it is folded in here so the chain end is not left dangling.
  assign hits_zero = dec_en && (digits_next == 16'h0000) && !borrow[4];

  // Next-state and expiry-pulse decision; load overrides everything.
  always_comb begin
    state_next         = state_reg;
    expired_pulse_next = 1'b0;
    if (load) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (digits_reg == 16'h0000) begin
              state_next         = EXPIRED;
              expired_pulse_next = 1'b1;
            end else begin
              state_next = RUNNING;
            end
          end
        end
        RUNNING: begin
          if (pause) begin
            state_next = PAUSED;
          end else if (hits_zero) begin
            state_next         = EXPIRED;
            expired_pulse_next = 1'b1;
          end
        end
        PAUSED: begin
          if (start) begin
            state_next = RUNNING;
          end
        end
        EXPIRED: begin
          state_next = EXPIRED;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State, digit and pulse registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg         <= IDLE;
      digits_reg        <= RESET_DIGITS;
      expired_pulse_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      digits_reg        <= digits_next;
      expired_pulse_reg <= expired_pulse_next;
    end
  end

  assign remaining     = bcd_to_seconds(digits_reg);
  assign digits        = digits_reg;
  assign running       = (state_reg == RUNNING);
  assign expired       = (state_reg == EXPIRED);
  assign expired_pulse = expired_pulse_reg;
  assign warning       = ((state_reg == RUNNING) || (state_reg == PAUSED)) &&
                         (remaining != 13'd0) &&
                         (remaining <= 13'(WARN_SECONDS));

endmodule

// File: tb/tb_countdown_clock.sv
// Self-checking bench for countdown_clock: directed scenarios plus a
// randomized run against a seconds-based reference model.
module tb_countdown_clock;

  localparam int DEF_MIN = 1;
  localparam int DEF_SEC = 30;
  localparam int WARN    = 10;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        tick = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_value = 16'h0000;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic [15:0] digits;
  logic        running, expired, expired_pulse, warning;

  int checks = 0;
  int failures = 0;

  // Reference model: remaining time as plain seconds, plus a state number.
  int m_state = M_IDLE;
  int m_rem   = DEF_MIN * 60 + DEF_SEC;
  bit m_pulse = 1'b0;

  countdown_clock #(
    .DEFAULT_MIN (DEF_MIN),
    .DEFAULT_SEC (DEF_SEC),
    .WARN_SECONDS(WARN)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .tick         (tick),
    .load         (load),
    .load_value   (load_value),
    .start        (start),
    .pause        (pause),
    .digits       (digits),
    .running      (running),
    .expired      (expired),
    .expired_pulse(expired_pulse),
    .warning      (warning)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] sec_to_bcd(input int rem);
    int m, s;
    m = rem / 60;
    s = rem % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic int sanitise(input logic [15:0] v);
    int mt, mo, st, so;
    mt = (v[15:12] > 9) ? 9 : int'(v[15:12]);
    mo = (v[11:8]  > 9) ? 9 : int'(v[11:8]);
    st = (v[7:4]   > 5) ? 5 : int'(v[7:4]);
    so = (v[3:0]   > 9) ? 9 : int'(v[3:0]);
    return (mt * 10 + mo) * 60 + st * 10 + so;
  endfunction

  // Drive one cycle of inputs, advance the model, then sample after the edge.
  task automatic step(input logic rst, input logic ld, input logic [15:0] lv,
                      input logic st, input logic ps, input logic tk);
    reset_n = rst; load = ld; load_value = lv; start = st; pause = ps; tick = tk;
    m_pulse = 1'b0;
    if (!rst) begin
      m_state = M_IDLE;
      m_rem   = DEF_MIN * 60 + DEF_SEC;
    end else if (ld) begin
      m_state = M_IDLE;
      m_rem   = sanitise(lv);
    end else begin
      case (m_state)
        M_IDLE:  if (st) begin
                   if (m_rem == 0) begin m_state = M_EXP; m_pulse = 1'b1; end
                   else m_state = M_RUN;
                 end
        M_RUN:   if (ps) m_state = M_PAUSE;
                 else if (tk) begin
                   m_rem = m_rem - 1;
                   if (m_rem == 0) begin m_state = M_EXP; m_pulse = 1'b1; end
                 end
        M_PAUSE: if (st) m_state = M_RUN;
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0;
  endtask

  task automatic idle();        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0); endtask
  task automatic do_tick();     step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1); endtask
  task automatic do_start();    step(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0); endtask
  task automatic do_load(input logic [15:0] v); step(1'b1, 1'b1, v, 1'b0, 1'b0, 1'b0); endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    checks++; if (digits !== 16'h0130) begin failures++; $display("FAIL reset_digits got=%h exp=0130", digits); end
    checks++; if (running !== 1'b0 || expired !== 1'b0 || expired_pulse !== 1'b0) begin
      failures++; $display("FAIL reset_flags got run=%b exp_lvl=%b pulse=%b exp=000", running, expired, expired_pulse); end
    do_tick();
    checks++; if (digits !== 16'h0130) begin failures++; $display("FAIL idle_tick got=%h exp=0130", digits); end
    $display("test_reset done digits=%h", digits);
  endtask

  task automatic test_expire();
    logic [15:0] exp_d [3];
    exp_d[0] = 16'h0002; exp_d[1] = 16'h0001; exp_d[2] = 16'h0000;
    do_load(16'h0003);
    do_start();
    checks++; if (running !== 1'b1) begin failures++; $display("FAIL start_running got=%b exp=1", running); end
    for (int i = 0; i < 3; i++) begin
      do_tick();
      checks++; if (digits !== exp_d[i]) begin failures++; $display("FAIL expire_tick%0d got=%h exp=%h", i, digits, exp_d[i]); end
      checks++; if (expired_pulse !== (i == 2)) begin failures++; $display("FAIL expire_pulse%0d got=%b exp=%b", i, expired_pulse, (i == 2)); end
    end
    do_tick();
    checks++; if (expired !== 1'b1 || expired_pulse !== 1'b0 || digits !== 16'h0000) begin
      failures++; $display("FAIL expire_hold got lvl=%b pulse=%b d=%h exp lvl=1 pulse=0 d=0000", expired, expired_pulse, digits); end
    do_start();
    checks++; if (expired !== 1'b1 || running !== 1'b0 || expired_pulse !== 1'b0) begin
      failures++; $display("FAIL expire_start got lvl=%b run=%b pulse=%b exp 1,0,0", expired, running, expired_pulse); end
    $display("test_expire done digits=%h expired=%b", digits, expired);
  endtask

  task automatic test_borrow();
    do_load(16'h1000); do_start(); do_tick();
    checks++; if (digits !== 16'h0959) begin failures++; $display("FAIL borrow_1000 got=%h exp=0959", digits); end
    do_load(16'h0100); do_start(); do_tick();
    checks++; if (digits !== 16'h0059) begin failures++; $display("FAIL borrow_0100 got=%h exp=0059", digits); end
    $display("test_borrow done digits=%h", digits);
  endtask

  task automatic test_pause();
    do_load(16'h0005); do_start();
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
    checks++; if (digits !== 16'h0005 || running !== 1'b0) begin
      failures++; $display("FAIL pause_tick got d=%h run=%b exp d=0005 run=0", digits, running); end
    checks++; if (warning !== 1'b1) begin failures++; $display("FAIL pause_warning got=%b exp=1", warning); end
    do_tick(); do_tick();
    checks++; if (digits !== 16'h0005) begin failures++; $display("FAIL paused_ticks got=%h exp=0005", digits); end
    do_start();
    checks++; if (running !== 1'b1) begin failures++; $display("FAIL resume got=%b exp=1", running); end
    do_tick();
    checks++; if (digits !== 16'h0004) begin failures++; $display("FAIL resume_tick got=%h exp=0004", digits); end
    $display("test_pause done digits=%h", digits);
  endtask

  task automatic test_warning();
    do_load(16'h0012); do_start();
    do_tick();
    checks++; if (digits !== 16'h0011 || warning !== 1'b0) begin
      failures++; $display("FAIL warn_11 got d=%h w=%b exp d=0011 w=0", digits, warning); end
    do_tick();
    checks++; if (digits !== 16'h0010 || warning !== 1'b1) begin
      failures++; $display("FAIL warn_10 got d=%h w=%b exp d=0010 w=1", digits, warning); end
    for (int i = 0; i < 10; i++) do_tick();
    checks++; if (expired !== 1'b1 || warning !== 1'b0) begin
      failures++; $display("FAIL warn_expired got lvl=%b w=%b exp lvl=1 w=0", expired, warning); end
    $display("test_warning done digits=%h", digits);
  endtask

  task automatic test_sanitise();
    do_load(16'h9F7C);
    checks++; if (digits !== 16'h9959) begin failures++; $display("FAIL clamp_9F7C got=%h exp=9959", digits); end
    do_load(16'h7A6F);
    checks++; if (digits !== 16'h7959) begin failures++; $display("FAIL clamp_7A6F got=%h exp=7959", digits); end
    do_load(16'h0000); do_start();
    checks++; if (expired_pulse !== 1'b1 || running !== 1'b0 || expired !== 1'b1) begin
      failures++; $display("FAIL zero_start got pulse=%b run=%b lvl=%b exp 1,0,1", expired_pulse, running, expired); end
    idle();
    checks++; if (expired_pulse !== 1'b0 || running !== 1'b0) begin
      failures++; $display("FAIL zero_after got pulse=%b run=%b exp 0,0", expired_pulse, running); end
    $display("test_sanitise done digits=%h", digits);
  endtask

  task automatic test_midreset();
    do_load(16'h0050); do_start();
    for (int i = 0; i < 8; i++) do_tick();
    checks++; if (digits !== 16'h0042) begin failures++; $display("FAIL midcount got=%h exp=0042", digits); end
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    checks++; if (digits !== 16'h0130 || running !== 1'b0 || expired !== 1'b0) begin
      failures++; $display("FAIL midreset got d=%h run=%b lvl=%b exp d=0130 0 0", digits, running, expired); end
    do_tick(); do_tick(); do_tick();
    checks++; if (digits !== 16'h0130) begin failures++; $display("FAIL reset_idle_ticks got=%h exp=0130", digits); end
    do_start(); do_tick();
    checks++; if (digits !== 16'h0129) begin failures++; $display("FAIL reset_then_run got=%h exp=0129", digits); end
    $display("test_midreset done digits=%h", digits);
  endtask

  task automatic test_random();
    int errs;
    logic [15:0] lv;
    logic rst, ld, st, ps, tk;
    bit exp_warn;
    errs = 0;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) != 0);
      ld  = ($urandom_range(0, 29) == 0);
      lv  = $urandom_range(0, 1) ? 16'($urandom)
                                 : {8'h00, 4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
      st  = ($urandom_range(0, 9) == 0);
      ps  = ($urandom_range(0, 19) == 0);
      tk  = st ? 1'b0 : ($urandom_range(0, 1) == 1);
      step(rst, ld, lv, st, ps, tk);
      exp_warn = ((m_state == M_RUN) || (m_state == M_PAUSE)) && (m_rem >= 1) && (m_rem <= WARN);
      checks++;
      if (digits !== sec_to_bcd(m_rem) || running !== (m_state == M_RUN) ||
          expired !== (m_state == M_EXP) || expired_pulse !== m_pulse || warning !== exp_warn) begin
        failures++; errs++;
        $display("FAIL random_cycle%0d got d=%h r=%b e=%b p=%b w=%b exp d=%h r=%b e=%b p=%b w=%b",
                 n, digits, running, expired, expired_pulse, warning,
                 sec_to_bcd(m_rem), (m_state == M_RUN), (m_state == M_EXP), m_pulse, exp_warn);
      end
    end
    $display("test_random done cycles=600 errors=%0d", errs);
  endtask

  initial begin
    test_reset();
    test_expire();
    test_borrow();
    test_pause();
    test_warning();
    test_sanitise();
    test_midreset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
